// File: rtl/fp16_mul_result_collector.sv
// Collector for FP16 multiplier products: classifies each accepted word, buffers it in a
// show-ahead FIFO and keeps sticky exception flags. Optional FP16_COLLECT_STATS_EN adds per-class counters.
module fp16_mul_result_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [1:0]               out_class,
    input  logic                     clear_flags,
    output logic                     flag_nan,
    output logic                     flag_inf,
    output logic                     flag_zero,
    output logic [$clog2(DEPTH):0]   fill_level
`ifdef FP16_COLLECT_STATS_EN
    ,
    output logic [CNT_W-1:0]         cnt_normal,
    output logic [CNT_W-1:0]         cnt_zero,
    output logic [CNT_W-1:0]         cnt_inf,
    output logic [CNT_W-1:0]         cnt_nan
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } class_t;

    logic [17:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_flag_nan;
    logic             r_flag_inf;
    logic             r_flag_zero;

    class_t           w_class;
    logic             w_push;
    logic             w_pop;

    // Subnormals (exp==0, man!=0) fall through to NORMAL; sign is ignored.
    always_comb begin
        w_class = CLS_NORMAL;
        if (in_result[14:10] == 5'h1F) begin
            w_class = (in_result[9:0] != 10'd0) ? CLS_NAN : CLS_INF;
        end else if (in_result[14:10] == 5'h00 && in_result[9:0] == 10'd0) begin
            w_class = CLS_ZERO;
        end
    end

    // in_ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready   = (r_count != LVL_FULL);
    assign out_valid  = (r_count != '0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign out_data   = r_mem[r_rd_ptr][15:0];
    assign out_class  = r_mem[r_rd_ptr][17:16];
    assign fill_level = r_count;
    assign flag_nan   = r_flag_nan;
    assign flag_inf   = r_flag_inf;
    assign flag_zero  = r_flag_zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_class, in_result};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
        end
    end

    // A new event in the same cycle as clear_flags leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flag_nan  <= 1'b0;
            r_flag_inf  <= 1'b0;
            r_flag_zero <= 1'b0;
        end else begin
            if (w_push && w_class == CLS_NAN) begin
                r_flag_nan <= 1'b1;
            end else if (clear_flags) begin
                r_flag_nan <= 1'b0;
            end
            if (w_push && w_class == CLS_INF) begin
                r_flag_inf <= 1'b1;
            end else if (clear_flags) begin
                r_flag_inf <= 1'b0;
            end
            if (w_push && w_class == CLS_ZERO) begin
                r_flag_zero <= 1'b1;
            end else if (clear_flags) begin
                r_flag_zero <= 1'b0;
            end
        end
    end

`ifdef FP16_COLLECT_STATS_EN
    logic [CNT_W-1:0] r_cnt [4];

    // Saturating counter step; clear with a simultaneous hit restarts at 1.
    function automatic logic [CNT_W-1:0] nextCnt(input logic [CNT_W-1:0] cnt,
                                                 input logic hit, input logic clr);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (clr) begin
            res = hit ? CNT_W'(1) : '0;
        end else if (hit && cnt != '1) begin
            res = cnt + CNT_W'(1);
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= nextCnt(r_cnt[i], w_push && (w_class == class_t'(i)), clear_flags);
            end
        end
    end

    assign cnt_normal = r_cnt[CLS_NORMAL];
    assign cnt_zero   = r_cnt[CLS_ZERO];
    assign cnt_inf    = r_cnt[CLS_INF];
    assign cnt_nan    = r_cnt[CLS_NAN];
`endif

endmodule

// File: tb/tb_fp16_mul_result_collector.sv
// Bench for fp16_mul_result_collector: directed scenarios plus random traffic against a queue model.
module tb_fp16_mul_result_collector;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_class;
    logic        clear_flags = 1'b0;
    logic        flag_nan;
    logic        flag_inf;
    logic        flag_zero;
    logic [2:0]  fill_level;
`ifdef FP16_COLLECT_STATS_EN
    logic [CNT_W-1:0] cnt_normal, cnt_zero, cnt_inf, cnt_nan;
`endif

    int checks = 0;
    int errors = 0;

    logic [17:0] refQ[$];
    bit          refFlag[4];
    int          refCnt[4];

    fp16_mul_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result(in_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_class(out_class),
        .clear_flags(clear_flags),
        .flag_nan(flag_nan),
        .flag_inf(flag_inf),
        .flag_zero(flag_zero),
        .fill_level(fill_level)
`ifdef FP16_COLLECT_STATS_EN
        ,
        .cnt_normal(cnt_normal),
        .cnt_zero(cnt_zero),
        .cnt_inf(cnt_inf),
        .cnt_nan(cnt_nan)
`endif
    );

    always #5 clk = ~clk;

    function automatic int refClass(input logic [15:0] w);
        int e, m;
        e = (int'(w) / 1024) % 32;
        m = int'(w) % 1024;
        if (e == 31 && m != 0) return 3;
        if (e == 31) return 2;
        if (e == 0 && m == 0) return 1;
        return 0;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the model, sampled 1 time unit after the edge.
    task automatic checkOutput();
        checkVal("in_ready", 32'(in_ready), 32'(refQ.size() < DEPTH));
        checkVal("out_valid", 32'(out_valid), 32'(refQ.size() > 0));
        checkVal("fill_level", 32'(fill_level), 32'(refQ.size()));
        if (refQ.size() > 0) begin
            checkVal("out_data", 32'(out_data), 32'(refQ[0][15:0]));
            checkVal("out_class", 32'(out_class), 32'(refQ[0][17:16]));
        end
        checkVal("flag_zero", 32'(flag_zero), 32'(refFlag[1]));
        checkVal("flag_inf", 32'(flag_inf), 32'(refFlag[2]));
        checkVal("flag_nan", 32'(flag_nan), 32'(refFlag[3]));
`ifdef FP16_COLLECT_STATS_EN
        checkVal("cnt_normal", 32'(cnt_normal), 32'(refCnt[0]));
        checkVal("cnt_zero", 32'(cnt_zero), 32'(refCnt[1]));
        checkVal("cnt_inf", 32'(cnt_inf), 32'(refCnt[2]));
        checkVal("cnt_nan", 32'(cnt_nan), 32'(refCnt[3]));
`endif
    endtask

    // One clock with the given inputs; the model decides accept/pop from its own occupancy.
    task automatic applyStimulus(input bit rst, input bit iv, input logic [15:0] word,
                                 input bit ordy, input bit clr);
        bit doPush, doPop;
        int cls;
        @(negedge clk);
        rst_n       = ~rst;
        in_valid    = iv;
        in_result   = word;
        out_ready   = ordy;
        clear_flags = clr;
        @(posedge clk);
        if (rst) begin
            refQ.delete();
            for (int i = 0; i < 4; i++) begin
                refFlag[i] = 1'b0;
                refCnt[i]  = 0;
            end
        end else begin
            doPush = iv && (refQ.size() < DEPTH);
            doPop  = ordy && (refQ.size() > 0);
            cls    = refClass(word);
            if (clr) begin
                for (int i = 0; i < 4; i++) begin
                    refFlag[i] = 1'b0;
                    refCnt[i]  = 0;
                end
            end
            if (doPop) void'(refQ.pop_front());
            if (doPush) begin
                refQ.push_back({2'(cls), word});
                refFlag[cls] = 1'b1;
                if (refCnt[cls] < (1 << CNT_W) - 1) refCnt[cls]++;
            end
        end
        #1;
        checkOutput();
    endtask

    initial begin
        logic [15:0] specials [8];
        logic [15:0] w;
        specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7C01, 16'h0001, 16'h3C00};

        // Reset state, including zeroed head word.
        applyStimulus(1, 0, 16'h0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0);
        checkVal("reset out_data", 32'(out_data), 32'h0);
        checkVal("reset out_class", 32'(out_class), 32'h0);

        // Scenario 1: single word appears one edge later.
        applyStimulus(0, 1, 16'h3C00, 1, 0);
        checkVal("s1 out_data", 32'(out_data), 32'h3C00);
        applyStimulus(0, 0, 16'h0, 1, 0);

        // Scenario 2: fill, refused fifth push, stable head, ordered drain.
        applyStimulus(0, 1, 16'h3C00, 0, 0);
        applyStimulus(0, 1, 16'h4000, 0, 0);
        applyStimulus(0, 1, 16'h4200, 0, 0);
        applyStimulus(0, 1, 16'h4400, 0, 0);
        checkVal("s2 full", 32'(in_ready), 32'h0);
        applyStimulus(0, 1, 16'h4500, 0, 0);
        checkVal("s2 head stable", 32'(out_data), 32'h3C00);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 16'h0, 1, 0);
        checkVal("s2 drained", 32'(fill_level), 32'h0);
        applyStimulus(0, 0, 16'h0, 1, 0);

        // Scenario 3: classes and flag clear leaves contents.
        applyStimulus(0, 1, 16'h7E00, 0, 0);
        applyStimulus(0, 1, 16'h7C00, 0, 0);
        applyStimulus(0, 1, 16'h8000, 0, 0);
        checkVal("s3 nan class", 32'(out_class), 32'h3);
        applyStimulus(0, 0, 16'h0, 0, 1);
        checkVal("s3 fill kept", 32'(fill_level), 32'h3);

        // Scenario 4: full FIFO, simultaneous valid and ready pops only.
        applyStimulus(0, 1, 16'h0001, 0, 0);
        applyStimulus(0, 1, 16'h4500, 1, 0);
        checkVal("s4 fill", 32'(fill_level), 32'h3);
        applyStimulus(0, 1, 16'h4500, 0, 0);
        checkVal("s4 accepted", 32'(fill_level), 32'h4);

        // Scenario 5: set wins over clear.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 16'h0, 1, 0);
        applyStimulus(0, 1, 16'h7C00, 0, 1);
        checkVal("s5 flag_inf", 32'(flag_inf), 32'h1);

        // Scenario 6: reset mid-traffic, then wrap through the pointers.
        applyStimulus(0, 1, 16'h1234, 0, 0);
        applyStimulus(0, 1, 16'h5678, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0);
        checkVal("s6 reset valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 11; i++) applyStimulus(0, 1, 16'h2000 + 16'(i), 1, 0);
        applyStimulus(0, 0, 16'h0, 1, 0);

        // Random traffic biased toward the special encodings.
        for (int i = 0; i < 500; i++) begin
            w = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 7)] : 16'($urandom);
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, w,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
